// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: matches up to MAX_WIDTH bits in overlapping or
// non-overlapping mode, with a registered detect pulse and a saturating match counter.
module seq_det_prog #(
   parameter int unsigned           MAX_WIDTH   = 8,
   parameter int unsigned           CNT_WIDTH   = 8,
   parameter logic [MAX_WIDTH-1:0]  RST_PATTERN = 8'b0001_0110,
   parameter int unsigned           RST_LEN     = 5,
   parameter bit                    RST_OVERLAP = 1'b1,
   localparam int unsigned          LEN_W       = $clog2(MAX_WIDTH + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cfg_we_i,
   input  logic [MAX_WIDTH-1:0] cfg_pattern_i,
   input  logic [LEN_W-1:0]     cfg_len_i,
   input  logic                 cfg_overlap_i,
   input  logic                 valid_i,
   input  logic                 data_i,
   input  logic                 clr_cnt_i,
   output logic                 detected_o,
   output logic [CNT_WIDTH-1:0] match_cnt_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic [MAX_WIDTH-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic                 overlap_q, overlap_d;
   // Only the newest MAX_WIDTH-1 bits can ever take part in a compare; the
   // current beat supplies the remaining bit.
   logic [MAX_WIDTH-2:0] history_q, history_d;
   logic [LEN_W-1:0]     fill_q, fill_d;
   logic                 detected_q, detected_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [MAX_WIDTH-1:0] window;
   logic [MAX_WIDTH-1:0] len_mask;
   logic                 match;

   assign window = {history_q, data_i};

   for (genvar gi = 0; gi < MAX_WIDTH; gi++) begin : g_mask
      assign len_mask[gi] = (LEN_W'(gi) < len_q);
   end

   // A config write in the same cycle drops the beat entirely.
   assign match = valid_i && !cfg_we_i
                  && (fill_q >= len_q - LEN_W'(1))
                  && (((window ^ pattern_q) & len_mask) == '0);

   always_comb begin
      pattern_d  = pattern_q;
      len_d      = len_q;
      overlap_d  = overlap_q;
      history_d  = history_q;
      fill_d     = fill_q;
      detected_d = match;
      cnt_d      = cnt_q;

      if (cfg_we_i) begin
         pattern_d = cfg_pattern_i;
         overlap_d = cfg_overlap_i;
         history_d = '0;
         fill_d    = '0;
         if (cfg_len_i == '0) begin
            len_d = LEN_W'(1);
         end else if (cfg_len_i > LEN_W'(MAX_WIDTH)) begin
            len_d = LEN_W'(MAX_WIDTH);
         end else begin
            len_d = cfg_len_i;
         end
      end else if (valid_i) begin
         history_d = window[MAX_WIDTH-2:0];
         if (match && !overlap_q) begin
            fill_d = '0;
         end else if (fill_q < len_q) begin
            fill_d = fill_q + LEN_W'(1);
         end
      end

      if (clr_cnt_i) begin
         cnt_d = '0;
      end else if (match && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pattern_q  <= RST_PATTERN;
         len_q      <= LEN_W'(RST_LEN);
         overlap_q  <= RST_OVERLAP;
         history_q  <= '0;
         fill_q     <= '0;
         detected_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         pattern_q  <= pattern_d;
         len_q      <= len_d;
         overlap_q  <= overlap_d;
         history_q  <= history_d;
         fill_q     <= fill_d;
         detected_q <= detected_d;
         cnt_q      <= cnt_d;
      end
   end

   assign detected_o  = detected_q;
   assign match_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog: the driver queues hand-computed expectations,
// a monitor pops and compares one entry per cycle after each rising edge.
module tb_seq_det_prog;

   localparam int MW = 8;
   localparam int CW = 2;
   localparam int LW = $clog2(MW + 1);

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          cfg_we_i = 1'b0;
   logic [MW-1:0] cfg_pattern_i = '0;
   logic [LW-1:0] cfg_len_i = '0;
   logic          cfg_overlap_i = 1'b0;
   logic          valid_i = 1'b0;
   logic          data_i = 1'b0;
   logic          clr_cnt_i = 1'b0;
   logic          detected_o;
   logic [CW-1:0] match_cnt_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          det;
      logic [CW-1:0] cnt;
      string         tag;
   } exp_t;

   exp_t exp_q[$];

   seq_det_prog #(.MAX_WIDTH(MW), .CNT_WIDTH(CW)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .cfg_we_i      (cfg_we_i),
      .cfg_pattern_i (cfg_pattern_i),
      .cfg_len_i     (cfg_len_i),
      .cfg_overlap_i (cfg_overlap_i),
      .valid_i       (valid_i),
      .data_i        (data_i),
      .clr_cnt_i     (clr_cnt_i),
      .detected_o    (detected_o),
      .match_cnt_o   (match_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step(input logic rst_n, input logic we, input logic v, input logic d,
                       input logic clr, input logic e_det, input logic [CW-1:0] e_cnt,
                       input string tag);
      exp_t e;
      @(negedge clk_i);
      rst_ni    = rst_n;
      cfg_we_i  = we;
      valid_i   = v;
      data_i    = d;
      clr_cnt_i = clr;
      e.det = e_det;
      e.cnt = e_cnt;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic beat(input logic d, input logic e_det, input logic [CW-1:0] e_cnt,
                       input string tag);
      step(1'b1, 1'b0, 1'b1, d, 1'b0, e_det, e_cnt, tag);
   endtask

   task automatic idle(input logic d, input logic clr, input logic [CW-1:0] e_cnt,
                       input string tag);
      step(1'b1, 1'b0, 1'b0, d, clr, 1'b0, e_cnt, tag);
   endtask

   task automatic load(input logic [MW-1:0] pat, input logic [LW-1:0] len, input logic ov,
                       input logic v, input logic d, input logic [CW-1:0] e_cnt,
                       input string tag);
      cfg_pattern_i = pat;
      cfg_len_i     = len;
      cfg_overlap_i = ov;
      step(1'b1, 1'b1, v, d, 1'b0, 1'b0, e_cnt, tag);
   endtask

   // Monitor: the DUT presents a fresh detect/count pair every cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (detected_o !== e.det || match_cnt_o !== e.cnt) begin
               errors++;
               $display("FAIL %s: got det=%0b cnt=%0d, expected det=%0b cnt=%0d",
                        e.tag, detected_o, match_cnt_o, e.det, e.cnt);
            end else begin
               $display("ok   %s: det=%0b cnt=%0d", e.tag, detected_o, match_cnt_o);
            end
         end
      end
   end

   initial begin
      // Reset state
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "reset_a");
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, "reset_b");
      idle(1'b0, 1'b0, 2'd0, "reset_release");

      // Reset config 10110/5/overlap: 1,0,1,1,0,1,1,0
      beat(1'b1, 1'b0, 2'd0, "ov_b1");
      beat(1'b0, 1'b0, 2'd0, "ov_b2");
      beat(1'b1, 1'b0, 2'd0, "ov_b3");
      beat(1'b1, 1'b0, 2'd0, "ov_b4");
      beat(1'b0, 1'b1, 2'd1, "ov_b5");
      beat(1'b1, 1'b0, 2'd1, "ov_b6");
      beat(1'b1, 1'b0, 2'd1, "ov_b7");
      beat(1'b0, 1'b1, 2'd2, "ov_b8");
      idle(1'b1, 1'b0, 2'd2, "ov_idle");

      // Non-overlapping 10110: only the first match counts
      load(8'b0001_0110, 4'd5, 1'b0, 1'b0, 1'b0, 2'd2, "nov_load");
      beat(1'b1, 1'b0, 2'd2, "nov_b1");
      beat(1'b0, 1'b0, 2'd2, "nov_b2");
      beat(1'b1, 1'b0, 2'd2, "nov_b3");
      beat(1'b1, 1'b0, 2'd2, "nov_b4");
      beat(1'b0, 1'b1, 2'd3, "nov_b5");
      beat(1'b1, 1'b0, 2'd3, "nov_b6");
      beat(1'b1, 1'b0, 2'd3, "nov_b7");
      beat(1'b0, 1'b0, 2'd3, "nov_b8");
      idle(1'b0, 1'b1, 2'd0, "nov_clr");

      // 101/3/overlap with valid gaps carrying junk data
      load(8'b0000_0101, 4'd3, 1'b1, 1'b0, 1'b0, 2'd0, "gap_load");
      beat(1'b1, 1'b0, 2'd0, "gap_b1");
      beat(1'b0, 1'b0, 2'd0, "gap_b2");
      idle(1'b1, 1'b0, 2'd0, "gap_idle1");
      idle(1'b1, 1'b0, 2'd0, "gap_idle2");
      idle(1'b0, 1'b0, 2'd0, "gap_idle3");
      beat(1'b1, 1'b1, 2'd1, "gap_b3");
      beat(1'b0, 1'b0, 2'd1, "gap_b4");
      beat(1'b1, 1'b1, 2'd2, "gap_b5");
      idle(1'b1, 1'b1, 2'd0, "gap_clr");

      // len 1: back-to-back pulses, saturation, clear on a match beat
      load(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0, "sat_load");
      beat(1'b1, 1'b1, 2'd1, "sat_b1");
      beat(1'b1, 1'b1, 2'd2, "sat_b2");
      beat(1'b1, 1'b1, 2'd3, "sat_b3");
      beat(1'b1, 1'b1, 2'd3, "sat_b4");
      beat(1'b1, 1'b1, 2'd3, "sat_b5");
      beat(1'b1, 1'b1, 2'd3, "sat_b6");
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, "sat_clr_match");
      beat(1'b0, 1'b0, 2'd0, "sat_zero");

      // Mid-stream reset clears history, fill and count
      load(8'b0001_0110, 4'd5, 1'b1, 1'b0, 1'b0, 2'd0, "rst_load");
      beat(1'b1, 1'b0, 2'd0, "rst_a1");
      beat(1'b0, 1'b0, 2'd0, "rst_a2");
      beat(1'b1, 1'b0, 2'd0, "rst_a3");
      beat(1'b1, 1'b0, 2'd0, "rst_a4");
      beat(1'b0, 1'b1, 2'd1, "rst_a5");
      beat(1'b1, 1'b0, 2'd1, "rst_b1");
      beat(1'b0, 1'b0, 2'd1, "rst_b2");
      beat(1'b1, 1'b0, 2'd1, "rst_b3");
      beat(1'b1, 1'b0, 2'd1, "rst_b4");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "rst_mid");
      beat(1'b0, 1'b0, 2'd0, "rst_after");

      // Same with a config write instead of reset
      beat(1'b1, 1'b0, 2'd0, "we_b1");
      beat(1'b0, 1'b0, 2'd0, "we_b2");
      beat(1'b1, 1'b0, 2'd0, "we_b3");
      beat(1'b1, 1'b0, 2'd0, "we_b4");
      load(8'b0001_0110, 4'd5, 1'b1, 1'b0, 1'b0, 2'd0, "we_reload");
      beat(1'b0, 1'b0, 2'd0, "we_after");

      // Length 0 clamps to 1
      load(8'b0000_0011, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0, "len0_load");
      beat(1'b1, 1'b1, 2'd1, "len0_b1");
      beat(1'b0, 1'b0, 2'd1, "len0_b2");
      beat(1'b1, 1'b1, 2'd2, "len0_b3");
      idle(1'b0, 1'b1, 2'd0, "len0_clr");

      // Oversized length clamps to 8: pattern A5 matches only after 8 beats
      load(8'hA5, 4'd15, 1'b0, 1'b0, 1'b0, 2'd0, "lenmax_load");
      beat(1'b1, 1'b0, 2'd0, "lenmax_b1");
      beat(1'b0, 1'b0, 2'd0, "lenmax_b2");
      beat(1'b1, 1'b0, 2'd0, "lenmax_b3");
      beat(1'b0, 1'b0, 2'd0, "lenmax_b4");
      beat(1'b0, 1'b0, 2'd0, "lenmax_b5");
      beat(1'b1, 1'b0, 2'd0, "lenmax_b6");
      beat(1'b0, 1'b0, 2'd0, "lenmax_b7");
      beat(1'b1, 1'b1, 2'd1, "lenmax_b8");

      // Config write on the final matching beat drops it and restarts fill
      load(8'b0001_0110, 4'd5, 1'b1, 1'b0, 1'b0, 2'd1, "drop_load");
      beat(1'b1, 1'b0, 2'd1, "drop_b1");
      beat(1'b0, 1'b0, 2'd1, "drop_b2");
      beat(1'b1, 1'b0, 2'd1, "drop_b3");
      beat(1'b1, 1'b0, 2'd1, "drop_b4");
      load(8'b0001_0110, 4'd5, 1'b1, 1'b1, 1'b0, 2'd1, "drop_we_beat");
      beat(1'b0, 1'b0, 2'd1, "drop_next0");
      beat(1'b1, 1'b0, 2'd1, "drop_c1");
      beat(1'b0, 1'b0, 2'd1, "drop_c2");
      beat(1'b1, 1'b0, 2'd1, "drop_c3");
      beat(1'b1, 1'b0, 2'd1, "drop_c4");
      beat(1'b0, 1'b1, 2'd2, "drop_c5");
      idle(1'b0, 1'b0, 2'd2, "final_idle");

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
